// File: rtl/vga_sync_recovery.sv
// Receive-side VGA timing recovery: recovers active-area coordinates, measures line/frame geometry, declares lock.
// Optional VGA_FRAME_CRC_EN adds frame_crc, a CRC-16-CCITT over each frame's valid {R,G,B} pixels.
module vga_sync_recovery #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        VGA_CLK,
  input  logic        RESET_N,
  input  logic        VGA_HS,
  input  logic        VGA_VS,
  input  logic        VGA_BLANK_N,
  input  logic [7:0]  VGA_R,
  input  logic [7:0]  VGA_G,
  input  logic [7:0]  VGA_B,
  output logic [7:0]  pix_R,
  output logic [7:0]  pix_G,
  output logic [7:0]  pix_B,
  output logic [9:0]  pix_col,
  output logic [8:0]  pix_row,
  output logic        pix_valid,
  output logic        frame_start,
  output logic [10:0] h_len,
  output logic [10:0] v_len,
  output logic        locked,
  output logic        sync_err
`ifdef VGA_FRAME_CRC_EN
  ,
  output logic [15:0] frame_crc
`endif
);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_e;

  localparam logic [10:0] SAT     = 11'h7FF;
  localparam logic [9:0]  COL_MAX = 10'(H_ACTIVE - 1);
  localparam logic [8:0]  ROW_MAX = 9'(V_ACTIVE - 1);

  logic       hsIn_q, vsIn_q, blankIn_q;
  logic       hsPrev_q, vsPrev_q, blankPrev_q;
  logic [7:0] rIn_q, gIn_q, bIn_q;

  logic [10:0] hCnt_q, vCnt_q, hLen_q, vLen_q, activeLines_q;
  logic        hSeen_q, vSeen_q, colOvf_q, frameBad_q;
  logic [9:0]  pixCol_q;
  logic [8:0]  pixRow_q;
  logic        pixValid_q, frameStart_q;
  logic [7:0]  pixR_q, pixG_q, pixB_q;

  state_e      state_q;
  logic [7:0]  goodCnt_q;
  logic        locked_q, syncErr_q;

  logic        hsFall, vsFall, blankRise, blankFall;
  logic [10:0] hLenNew, vCntInc;
  logic        lineViol, colOvf, widthViol, frameViol, anyViol, syncLost;
  logic [7:0]  goodNext;

  // Sync history idles high so release from reset never looks like a falling edge
  always_ff @(posedge VGA_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      hsIn_q      <= 1'b1;
      vsIn_q      <= 1'b1;
      blankIn_q   <= 1'b0;
      hsPrev_q    <= 1'b1;
      vsPrev_q    <= 1'b1;
      blankPrev_q <= 1'b0;
      rIn_q       <= '0;
      gIn_q       <= '0;
      bIn_q       <= '0;
    end else begin
      hsIn_q      <= VGA_HS;
      vsIn_q      <= VGA_VS;
      blankIn_q   <= VGA_BLANK_N;
      hsPrev_q    <= hsIn_q;
      vsPrev_q    <= vsIn_q;
      blankPrev_q <= blankIn_q;
      rIn_q       <= VGA_R;
      gIn_q       <= VGA_G;
      bIn_q       <= VGA_B;
    end
  end

  always_comb begin
    hsFall    = hsPrev_q & ~hsIn_q;
    vsFall    = vsPrev_q & ~vsIn_q;
    blankRise = blankIn_q & ~blankPrev_q;
    blankFall = ~blankIn_q & blankPrev_q;
    hLenNew   = (hCnt_q == SAT) ? SAT : hCnt_q + 11'd1;
    // A coincident HS fall is counted before the VS fall closes the frame
    vCntInc   = (hsFall && vCnt_q != SAT) ? vCnt_q + 11'd1 : vCnt_q;
    lineViol  = hsFall & hSeen_q & (hLenNew != 11'(H_TOTAL));
    colOvf    = blankIn_q & ~blankRise & (pixCol_q == COL_MAX) & ~colOvf_q;
    widthViol = colOvf | (blankFall & (pixCol_q != COL_MAX));
    frameViol = vsFall & vSeen_q &
                ((vCntInc != 11'(V_TOTAL)) | (activeLines_q != 11'(V_ACTIVE)));
    anyViol   = lineViol | widthViol | frameViol;
    syncLost  = ~hsFall & (hCnt_q == SAT - 11'd1);
    goodNext  = goodCnt_q + 8'd1;
  end

  always_ff @(posedge VGA_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      hCnt_q        <= '0;
      vCnt_q        <= '0;
      hLen_q        <= '0;
      vLen_q        <= '0;
      hSeen_q       <= 1'b0;
      vSeen_q       <= 1'b0;
      activeLines_q <= '0;
      pixCol_q      <= '0;
      pixRow_q      <= '0;
      colOvf_q      <= 1'b0;
      frameBad_q    <= 1'b0;
      pixValid_q    <= 1'b0;
      frameStart_q  <= 1'b0;
      pixR_q        <= '0;
      pixG_q        <= '0;
      pixB_q        <= '0;
    end else begin
      if (hsFall)
        hCnt_q <= '0;
      else if (hCnt_q != SAT)
        hCnt_q <= hCnt_q + 11'd1;
      if (hsFall && hSeen_q)
        hLen_q <= hLenNew;
      if (syncLost)
        hSeen_q <= 1'b0;
      else if (hsFall)
        hSeen_q <= 1'b1;

      vCnt_q <= vsFall ? 11'd0 : vCntInc;
      if (vsFall && vSeen_q)
        vLen_q <= vCntInc;
      if (syncLost)
        vSeen_q <= 1'b0;
      else if (vsFall)
        vSeen_q <= 1'b1;

      if (blankRise)
        pixCol_q <= '0;
      else if (blankIn_q && pixCol_q != COL_MAX)
        pixCol_q <= pixCol_q + 10'd1;
      if (blankRise)
        colOvf_q <= 1'b0;
      else if (colOvf)
        colOvf_q <= 1'b1;

      // Row 0 belongs to the first active line after VS; later lines advance it
      if (vsFall) begin
        activeLines_q <= '0;
        pixRow_q      <= '0;
      end else if (blankRise) begin
        if (activeLines_q != 11'd0 && pixRow_q != ROW_MAX)
          pixRow_q <= pixRow_q + 9'd1;
        if (activeLines_q != SAT)
          activeLines_q <= activeLines_q + 11'd1;
      end

      if (vsFall)
        frameBad_q <= 1'b0;
      else if (lineViol || widthViol)
        frameBad_q <= 1'b1;

      pixValid_q   <= blankIn_q;
      frameStart_q <= vsFall;
      pixR_q       <= blankIn_q ? rIn_q : 8'd0;
      pixG_q       <= blankIn_q ? gIn_q : 8'd0;
      pixB_q       <= blankIn_q ? bIn_q : 8'd0;
    end
  end

  // Loss of sync overrides every state; only a locked block reports it
  always_ff @(posedge VGA_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= SEARCH;
      goodCnt_q <= '0;
      locked_q  <= 1'b0;
      syncErr_q <= 1'b0;
    end else if (syncLost) begin
      state_q   <= SEARCH;
      goodCnt_q <= '0;
      locked_q  <= 1'b0;
      syncErr_q <= (state_q == LOCKED);
    end else begin
      syncErr_q <= 1'b0;
      case (state_q)
        SEARCH: begin
          if (vsFall) begin
            state_q   <= MEASURE;
            goodCnt_q <= '0;
          end
        end
        MEASURE: begin
          syncErr_q <= anyViol;
          if (vsFall) begin
            if (frameBad_q || anyViol) begin
              goodCnt_q <= '0;
            end else if (goodNext >= 8'(LOCK_FRAMES)) begin
              state_q   <= LOCKED;
              locked_q  <= 1'b1;
              goodCnt_q <= goodNext;
            end else begin
              goodCnt_q <= goodNext;
            end
          end
        end
        LOCKED: begin
          syncErr_q <= anyViol;
          if (anyViol) begin
            state_q   <= MEASURE;
            locked_q  <= 1'b0;
            goodCnt_q <= '0;
          end
        end
        default: state_q <= SEARCH;
      endcase
    end
  end

`ifdef VGA_FRAME_CRC_EN
  logic [15:0] crcRun_q, frameCrc_q, crcNext;

  function automatic logic [15:0] crcStep(input logic [15:0] crcIn, input logic [23:0] data);
    logic [15:0] c;
    logic        fb;
    c = crcIn;
    for (int i = 23; i >= 0; i--) begin
      fb = c[15] ^ data[i];
      c  = {c[14:0], 1'b0};
      if (fb)
        c = c ^ 16'h1021;
    end
    return c;
  endfunction

  always_comb begin
    crcNext = blankIn_q ? crcStep(crcRun_q, {rIn_q, gIn_q, bIn_q}) : crcRun_q;
  end

  always_ff @(posedge VGA_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      crcRun_q   <= 16'hFFFF;
      frameCrc_q <= '0;
    end else if (vsFall) begin
      frameCrc_q <= crcNext;
      crcRun_q   <= 16'hFFFF;
    end else begin
      crcRun_q   <= crcNext;
    end
  end

  assign frame_crc = frameCrc_q;
`endif

  assign pix_R       = pixR_q;
  assign pix_G       = pixG_q;
  assign pix_B       = pixB_q;
  assign pix_col     = pixCol_q;
  assign pix_row     = pixRow_q;
  assign pix_valid   = pixValid_q;
  assign frame_start = frameStart_q;
  assign h_len       = hLen_q;
  assign v_len       = vLen_q;
  assign locked      = locked_q;
  assign sync_err    = syncErr_q;

endmodule

// File: tb/tb_vga_sync_recovery.sv
// Directed bench for vga_sync_recovery on a scaled 40x20 raster (16x12 active) to keep runs short.
// Frame CRC is checked only when VGA_FRAME_CRC_EN is defined.
module tb_vga_sync_recovery;

  localparam int HT = 40;
  localparam int HA = 16;
  localparam int VT = 20;
  localparam int VA = 12;

  logic        VGA_CLK = 1'b0;
  logic        RESET_N;
  logic        VGA_HS, VGA_VS, VGA_BLANK_N;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic [7:0]  pix_R, pix_G, pix_B;
  logic [9:0]  pix_col;
  logic [8:0]  pix_row;
  logic        pix_valid, frame_start, locked, sync_err;
  logic [10:0] h_len, v_len;
`ifdef VGA_FRAME_CRC_EN
  logic [15:0] frame_crc;
  logic [15:0] expCrc;
`endif

  int errors = 0;
  int checks = 0;
  int syncErrCnt = 0;
  int gf, gx, gy;
  int longF = -1;
  int longY = -1;
  bit rgbZero = 1'b0;

  always #5 VGA_CLK = ~VGA_CLK;

  vga_sync_recovery #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA), .LOCK_FRAMES(2)
  ) dut (
    .VGA_CLK(VGA_CLK), .RESET_N(RESET_N),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .pix_R(pix_R), .pix_G(pix_G), .pix_B(pix_B),
    .pix_col(pix_col), .pix_row(pix_row), .pix_valid(pix_valid),
    .frame_start(frame_start), .h_len(h_len), .v_len(v_len),
    .locked(locked), .sync_err(sync_err)
`ifdef VGA_FRAME_CRC_EN
    , .frame_crc(frame_crc)
`endif
  );

  // Counts sync_err pulses while out of reset so the steps can check totals
  always @(negedge VGA_CLK) begin
    if (RESET_N === 1'b1 && sync_err === 1'b1)
      syncErrCnt++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // HS low x=2..5, VS low lines 2..3, active x=24..39 on lines 8..19
  task automatic driveInputs();
    VGA_HS      = !(gx >= 2 && gx <= 5);
    VGA_VS      = !(gy == 2 || gy == 3);
    VGA_BLANK_N = (gx >= 24 && gx <= 39 && gy >= 8);
    VGA_R       = rgbZero ? 8'd0 : 8'(gx);
    VGA_G       = rgbZero ? 8'd0 : 8'(gy);
    VGA_B       = rgbZero ? 8'd0 : 8'h5A;
  endtask

  task automatic applyStimulus(input int n);
    int lineLen;
    repeat (n) begin
      driveInputs();
      @(posedge VGA_CLK);
      #1;
      lineLen = (gf == longF && gy == longY) ? HT + 1 : HT;
      gx++;
      if (gx >= lineLen) begin
        gx = 0;
        gy++;
        if (gy >= VT) begin
          gy = 0;
          gf++;
        end
      end
    end
  endtask

  task automatic idleCycles(input int n);
    VGA_HS = 1'b1; VGA_VS = 1'b1; VGA_BLANK_N = 1'b0;
    VGA_R = 8'd0; VGA_G = 8'd0; VGA_B = 8'd0;
    repeat (n) begin
      @(posedge VGA_CLK);
      #1;
    end
  endtask

  task automatic runTo(input int f, input int x, input int y);
    int budget = 0;
    while (!(gf == f && gx == x && gy == y) && budget < 5000) begin
      applyStimulus(1);
      budget++;
    end
    checkOutput("runTo_reached", 32'(gf == f && gx == x && gy == y), 1);
  endtask

`ifdef VGA_FRAME_CRC_EN
  function automatic logic [15:0] crcZeroBytes(input int nBytes);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < nBytes * 8; i++)
      c = c[15] ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
    return c;
  endfunction
`endif

  initial begin
    RESET_N = 1'b0;
    gf = 0; gx = 0; gy = 0;
    idleCycles(3);
    checkOutput("rst_locked", 32'(locked), 0);
    checkOutput("rst_sync_err", 32'(sync_err), 0);
    checkOutput("rst_pix_valid", 32'(pix_valid), 0);
    checkOutput("rst_h_len", 32'(h_len), 0);
    checkOutput("rst_v_len", 32'(v_len), 0);
    checkOutput("rst_frame_start", 32'(frame_start), 0);
    checkOutput("rst_pix_col", 32'(pix_col), 0);
    checkOutput("rst_pix_row", 32'(pix_row), 0);
    RESET_N = 1'b1;

    // Nominal timing: first VS enters MEASURE, lock on the second frame end
    runTo(1, 0, 2);
    checkOutput("first_vs_no_vlen", 32'(v_len), 0);
    checkOutput("h_len_nominal", 32'(h_len), HT);
    applyStimulus(2);
    checkOutput("v_len_nominal", 32'(v_len), VT);
    checkOutput("not_locked_after_1", 32'(locked), 0);
    runTo(2, 0, 2);
    applyStimulus(1);
    checkOutput("frame_start_pre", 32'(frame_start), 0);
    checkOutput("lock_pre", 32'(locked), 0);
    applyStimulus(1);
    checkOutput("frame_start_pulse", 32'(frame_start), 1);
    checkOutput("lock_rise", 32'(locked), 1);
    applyStimulus(1);
    checkOutput("frame_start_end", 32'(frame_start), 0);
    checkOutput("no_sync_err_nominal", 32'(syncErrCnt), 0);

    // Coordinates of first and last active pixel, two cycles after input
    runTo(2, 24, 8);
    applyStimulus(1);
    checkOutput("pre_first_valid", 32'(pix_valid), 0);
    checkOutput("pre_first_B_zeroed", 32'(pix_B), 0);
    applyStimulus(1);
    checkOutput("first_valid", 32'(pix_valid), 1);
    checkOutput("first_col", 32'(pix_col), 0);
    checkOutput("first_row", 32'(pix_row), 0);
    checkOutput("first_R", 32'(pix_R), 24);
    checkOutput("first_G", 32'(pix_G), 8);
    runTo(2, 39, 19);
    applyStimulus(2);
    checkOutput("last_valid", 32'(pix_valid), 1);
    checkOutput("last_col", 32'(pix_col), HA - 1);
    checkOutput("last_row", 32'(pix_row), VA - 1);
    checkOutput("last_R", 32'(pix_R), 39);
    checkOutput("last_B", 32'(pix_B), 8'h5A);
    applyStimulus(1);
    checkOutput("after_last_valid", 32'(pix_valid), 0);
    checkOutput("after_last_R", 32'(pix_R), 0);

    // One 41-cycle line in frame 3 breaks lock, relock after two clean frames
    longF = 3; longY = 10;
    runTo(3, 2, 11);
    applyStimulus(1);
    checkOutput("long_pre_err", 32'(sync_err), 0);
    checkOutput("long_pre_locked", 32'(locked), 1);
    applyStimulus(1);
    checkOutput("long_sync_err", 32'(sync_err), 1);
    checkOutput("long_unlocked", 32'(locked), 0);
    checkOutput("long_h_len", 32'(h_len), HT + 1);
    applyStimulus(1);
    checkOutput("long_err_single", 32'(sync_err), 0);
    runTo(5, 0, 2);
    applyStimulus(2);
    checkOutput("relock_not_yet", 32'(locked), 0);
    checkOutput("relock_h_len", 32'(h_len), HT);
    runTo(6, 0, 2);
    applyStimulus(1);
    checkOutput("relock_pre", 32'(locked), 0);
    applyStimulus(1);
    checkOutput("relock", 32'(locked), 1);
    checkOutput("long_err_count", 32'(syncErrCnt), 1);

    // Stream stalls with syncs idle for 3000 cycles
    runTo(6, 0, 12);
    idleCycles(3000);
    checkOutput("stall_unlocked", 32'(locked), 0);
    checkOutput("stall_err_count", 32'(syncErrCnt), 2);
    checkOutput("stall_err_low", 32'(sync_err), 0);
    gf = 7; gx = 0; gy = 0;
    runTo(8, 0, 2);
    applyStimulus(2);
    checkOutput("stall_relock_not_yet", 32'(locked), 0);
    runTo(9, 0, 2);
    applyStimulus(1);
    checkOutput("stall_relock_pre", 32'(locked), 0);
    applyStimulus(1);
    checkOutput("stall_relock", 32'(locked), 1);
    checkOutput("stall_relock_errs", 32'(syncErrCnt), 2);

    // Reset mid-line while locked
    runTo(9, 30, 10);
    checkOutput("pre_reset_col", 32'(pix_col), 4);
    RESET_N = 1'b0;
    #1;
    checkOutput("mid_rst_locked", 32'(locked), 0);
    checkOutput("mid_rst_valid", 32'(pix_valid), 0);
    checkOutput("mid_rst_col", 32'(pix_col), 0);
    checkOutput("mid_rst_row", 32'(pix_row), 0);
    checkOutput("mid_rst_h_len", 32'(h_len), 0);
    checkOutput("mid_rst_v_len", 32'(v_len), 0);
    checkOutput("mid_rst_R", 32'(pix_R), 0);
    applyStimulus(3);
    RESET_N = 1'b1;
    rgbZero = 1'b1;
    runTo(9, 2, 12);
    applyStimulus(1);
    checkOutput("rst_first_hs_no_update", 32'(h_len), 0);
    applyStimulus(1);
    checkOutput("rst_second_hs_update", 32'(h_len), HT);
    runTo(10, 0, 10);
    checkOutput("rst_no_sync_err", 32'(syncErrCnt), 2);

`ifdef VGA_FRAME_CRC_EN
    expCrc = crcZeroBytes(HA * VA * 3);
    runTo(11, 0, 2);
    applyStimulus(2);
    checkOutput("crc_zero_frame", 32'(frame_crc), 32'(expCrc));
    runTo(12, 0, 2);
    applyStimulus(2);
    checkOutput("crc_zero_frame_repeat", 32'(frame_crc), 32'(expCrc));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_sync_recovery.md
Name: vga_sync_recovery

Overview:
- Receive-side counterpart of the VGA timing generator: consumes the HS/VS/BLANK_N/RGB stream on VGA_CLK.
- Recovers active-area column/row coordinates, measures line and frame geometry, and declares lock.
- Sits in loopback/verification paths: it sees what the monitor sees, and downstream checkers or overlays consume its coordinates.

Parameters:
- H_TOTAL, 800, expected VGA_CLK cycles between consecutive HS falling edges
- V_TOTAL, 525, expected lines (HS falls) between consecutive VS falling edges
- H_ACTIVE, 640, expected BLANK_N-high pixels per active line
- V_ACTIVE, 480, expected active lines per frame
- LOCK_FRAMES, 2, consecutive good frames required to assert locked

Ports:
- VGA_CLK  input  1  pixel clock; all logic on rising edge
- RESET_N  input  1  asynchronous, active-low reset
- VGA_HS  input  1  horizontal sync, active low
- VGA_VS  input  1  vertical sync, active low
- VGA_BLANK_N  input  1  high during active pixels
- VGA_R, VGA_G, VGA_B  input  8 each  pixel data
- pix_R, pix_G, pix_B  output  8 each  registered pixel data aligned to pix_col/pix_row
- pix_col  output  10  active column, 0..H_ACTIVE-1
- pix_row  output  9  active row, 0..V_ACTIVE-1
- pix_valid  output  1  high when pix_* carry an active pixel
- frame_start  output  1  one-cycle pulse on VS falling edge
- h_len  output  11  last measured line length in cycles, saturating at 2047
- v_len  output  11  last measured frame length in lines, saturating at 2047
- locked  output  1  geometry stable
- sync_err  output  1  one-cycle pulse on any geometry violation

Behaviour:
- Reset (async, RESET_N=0): every output is 0, state=SEARCH, and all counters and edge-history registers are cleared. The edge history is cleared to 1 (idle-high syncs), so no false edge is seen after release.
- Input stage: one register on all inputs. Edges are detected by comparing the registered value with the previous registered value.
- Latency: an input sample at cycle n appears on pix_*/pix_valid at cycle n+2. frame_start is asserted 2 cycles after the VS falling-edge sample.
- h counter: increments every cycle and saturates at 2047. On an HS fall:
  - h_len <= count+1, then the counter restarts at 0.
  - The first HS fall after reset or after SEARCH only starts counting; h_len is not updated.
- Line-length check: on each HS fall, the line is good iff count+1 == H_TOTAL.
- v counter: increments on each HS fall and saturates. On a VS fall:
  - v_len <= count, then the counter restarts at 0.
  - Same first-edge rule as the h counter.
- Column tracking:
  - pix_col resets to 0 on each BLANK_N rising edge and increments while BLANK_N stays high.
  - At H_ACTIVE-1 it saturates and raises an active-width violation.
  - A line whose BLANK_N-high run is not exactly H_ACTIVE is bad.
- Row tracking:
  - pix_row is 0 on a VS fall and increments at the first BLANK_N rise of each subsequent active line.
  - It saturates at V_ACTIVE-1. A frame whose active-line count is not V_ACTIVE is bad.
- pix_valid = registered BLANK_N. pix_R/G/B are forced to 0 when pix_valid=0.
- FSM:
  - SEARCH: wait for a VS fall, then go to MEASURE with good_cnt=0.
  - MEASURE:
    - At each VS fall, a frame with no violations increments good_cnt; otherwise good_cnt=0.
    - When good_cnt reaches LOCK_FRAMES, go to LOCKED and set locked=1.
  - LOCKED: any violation (bad line length, bad width, or a VS fall with v_len!=V_TOTAL or active rows!=V_ACTIVE) causes:
    - sync_err pulse on the cycle after detection
    - locked=0 on the same cycle as the pulse
    - transition to MEASURE with good_cnt=0
  - sync_err also pulses on violations seen in MEASURE; it never pulses in SEARCH.
- Simultaneous HS and VS fall in the same cycle: process the HS fall first (line closes, v count increments), then the VS fall closes the frame with the incremented count.
- Sync lost (no HS fall for 2047 cycles):
  - h counter saturates; go to SEARCH; locked=0.
  - One sync_err pulse is issued if the block was LOCKED.
- Reset mid-frame: immediate return to reset values. No sync_err.

Optional Feature:
- Macro VGA_FRAME_CRC_EN.
- Defined:
  - Adds output frame_crc[15:0]: CRC-16-CCITT (poly 0x1021, init 0xFFFF) over {R,G,B}, MSB first, for each valid pixel of a frame.
  - Latched into frame_crc at each VS fall; the running CRC is then re-initialised.
  - frame_crc resets to 0.
- Undefined: no frame_crc port and no CRC logic.

Test Plan:
- Nominal 800x525 timing (HS low x=2..97, VS low lines 13..14, active x=160..799, y=45..524) -> h_len=800, v_len=525; locked rises at the 2nd frame-end VS fall; no sync_err.
- Locked stream, check coordinates -> first active pixel gives pix_col=0, pix_row=0, pix_valid=1 two cycles after input. Last pixel gives pix_col=639, pix_row=479.
- Locked stream, one line lengthened to 801 cycles -> one sync_err pulse, locked=0, h_len=801. Relock after 2 clean frames.
- Locked stream, HS held high for 3000 cycles -> state SEARCH, single sync_err, locked=0. Restored timing relocks within 3 VS falls.
- RESET_N pulsed low mid-line while locked -> all outputs 0 immediately. No sync_err after release; first h_len update after the second HS fall.
- With VGA_FRAME_CRC_EN, constant pixel 0x000000 for a full frame -> frame_crc equals the reference-model CRC of 921600 zero bytes. The value is stable and identical on consecutive frames.
